sv32_ptw: RTL and testbench
===========================

Name: sv32_ptw

Overview:
- Sv32 hardware page-table walker that sits directly upstream of cva6_tlb_sv32.
- Accepts a TLB lookup miss, walks the two-level Sv32 page table through a single-outstanding memory read port, and produces the TLB refill word on update_o. update_o connects straight to the TLB update_i.
- A walk that ends in a bad PTE or a memory error raises a one-cycle fault pulse instead of a refill.
- A flush aborts any in-flight walk without refilling the TLB.

Parameters:
ASID_WIDTH, 9, ASID field width in the miss request and in update_o.
PTW_USE_ACCESSED, 1, when 1 a leaf with A=0 faults; there is no hardware A/D update.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  abort walk, drop pending miss
miss_valid_i  in  1  TLB miss request
miss_vaddr_i  in  32  faulting virtual address
miss_asid_i  in  ASID_WIDTH  ASID of the miss
satp_ppn_i  in  22  root page-table PPN
busy_o  out  1  walk in progress (state != IDLE)
req_valid_o  out  1  memory read request
req_ready_i  in  1  memory accepts request
req_addr_o  out  34  physical PTE address
rsp_valid_i  in  1  read data valid
rsp_data_i  in  32  PTE read
rsp_err_i  in  1  bus error, qualified by rsp_valid_i
update_o  out  2+20+ASID_WIDTH+32  {valid, is_4M, vpn[19:0], asid, pte[31:0]}, matching TLB update_i
fault_o  out  1  one-cycle walk-failure pulse
fault_access_o  out  1  1 = bus error, 0 = page fault; valid with fault_o
fault_vaddr_o  out  32  vaddr of the last failed walk

Behaviour:
Reset:
- All outputs are 0 and state = IDLE.
- Internal vaddr, asid and pte registers are 0.

States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, DRAIN.
- IDLE: if miss_valid_i && !flush_i, latch vaddr/asid, clear fault_vaddr_o, go to L1_REQ. A miss arriving while busy_o=1 is ignored; the requester re-issues it.
- L1_REQ: req_valid_o=1, req_addr_o = {satp_ppn_i, 12'b0} + vpn[19:10]*4. The address is held stable until req_ready_i. On handshake go to L1_WAIT.
- L1_WAIT: on rsp_valid_i, latch the PTE and decide:
  - rsp_err_i: FAULT with access=1.
  - V=0, or (R=0 && W=1): FAULT with access=0.
  - Leaf (R|X) with pte[19:10] != 0 (misaligned superpage): FAULT.
  - Leaf with A=0 and PTW_USE_ACCESSED=1: FAULT.
  - Leaf otherwise: DONE with is_4M=1.
  - Non-leaf: L0_REQ.
- L0_REQ: req_addr_o = {pte[31:10], 12'b0} + vpn[9:0]*4. Same handshake rule as L1_REQ; go to L0_WAIT.
- L0_WAIT: same checks as L1_WAIT, except a non-leaf PTE is a page fault. A good leaf goes to DONE with is_4M=0.
- DONE: update_o valid for exactly one cycle = {1, is_4M, vaddr[31:12], asid, pte}. Then IDLE. update_o is all-zero in every other cycle.
- FAULT: fault_o=1 for one cycle, fault_vaddr_o = latched vaddr (held until the next accepted miss). Then IDLE.
- DRAIN: wait for rsp_valid_i, discard the data (even if err), go to IDLE.

Flush:
- flush_i in L1_REQ or L0_REQ: go to IDLE. If req_ready_i was high that same cycle, go to DRAIN instead, since the request was accepted.
- flush_i in L1_WAIT or L0_WAIT: go to DRAIN, or to IDLE if rsp_valid_i arrives that same cycle. No update or fault is issued.
- flush_i in DONE or FAULT: the pulse is suppressed.
- flush_i in DRAIN: no effect.

Memory port and latency:
- At most one outstanding request. rsp_valid_i is never accepted in a *_REQ state.
- Best case, with ready=1 and the response one cycle after the handshake, counting the miss at cycle T:
  - 4 KiB page: req T+1, rsp T+2, req T+3, rsp T+4, update_o at T+5.
  - Superpage: update_o at T+3.

Address arithmetic: 34-bit, no wrap.

Reset mid-walk: returns to IDLE immediately. The memory side must tolerate a dropped response.

Test Plan:
1. 4 KiB walk:
   - Stimulus: satp_ppn=0x00080, miss vaddr=0x12345000, asid=1. L1 rsp 0x00024001, L0 rsp 0x0002ACC7.
   - Required: req addresses 0x80120 then 0x90D14; update_o={1,0,20'h12345,9'h001,32'h0002ACC7} at T+5.
2. Superpage:
   - Stimulus: same miss, L1 rsp 0x001000CF.
   - Required: a single request; update_o={1,1,20'h12345,9'h001,32'h001000CF} at T+3.
3. Misaligned superpage:
   - Stimulus: L1 rsp 0x001004CF.
   - Required: fault_o pulse, fault_access_o=0, fault_vaddr_o=0x12345000, update_o stays 0.
4. Bus error:
   - Stimulus: L0 rsp with rsp_err_i=1.
   - Required: fault_o with fault_access_o=1; busy_o drops the next cycle.
5. Flush while waiting:
   - Stimulus: flush_i in L1_WAIT, response 3 cycles later. A new miss presented during DRAIN is ignored.
   - Required: no update_o/fault_o; busy_o low the cycle after the response.
6. Backpressure and reset:
   - Stimulus: req_ready_i=0 for 4 cycles.
   - Required: req_addr_o stable and req_valid_o held.
   - Stimulus: rst_ni low mid-L0_WAIT.
   - Required: all outputs 0 and IDLE asynchronously.

Source files
------------

// File: rtl/sv32_ptw_if.sv
// Memory read port of the Sv32 page-table walker: one request, one response,
// at most one outstanding.
interface sv32_ptw_if;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [33:0] req_addr_o;
   logic        rsp_valid_i;
   logic [31:0] rsp_data_i;
   logic        rsp_err_i;

   modport master (output req_valid_o, req_addr_o,
                   input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i);
   modport slave  (input  req_valid_o, req_addr_o,
                   output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i);
endinterface

// File: rtl/sv32_ptw.sv
// Sv32 two-level hardware page-table walker feeding the TLB refill port.
// Walks on a TLB miss, emits a one-cycle refill on success or a fault pulse otherwise.
module sv32_ptw #(
   parameter int ASID_WIDTH       = 9,
   parameter bit PTW_USE_ACCESSED = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         miss_valid_i,
   input  logic [31:0]                  miss_vaddr_i,
   input  logic [ASID_WIDTH-1:0]        miss_asid_i,
   input  logic [21:0]                  satp_ppn_i,
   output logic                         busy_o,
   sv32_ptw_if.master                   mem,
   output logic [2+20+ASID_WIDTH+32-1:0] update_o,
   output logic                         fault_o,
   output logic                         fault_access_o,
   output logic [31:0]                  fault_vaddr_o
);

   typedef enum logic [2:0] {
      IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           vaddr_q, pte_q;
   logic [ASID_WIDTH-1:0] asid_q;
   logic                  is_4m_q, access_q;

   // Classification of the PTE currently on the response bus
   logic p_bad, p_leaf, p_misal, p_noacc;
   assign p_bad   = !mem.rsp_data_i[0] || (!mem.rsp_data_i[1] && mem.rsp_data_i[2]);
   assign p_leaf  = mem.rsp_data_i[1] | mem.rsp_data_i[3];
   assign p_misal = mem.rsp_data_i[19:10] != 10'd0;
   assign p_noacc = PTW_USE_ACCESSED && !mem.rsp_data_i[6];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (miss_valid_i && !flush_i) state_d = L1_REQ;
         L1_REQ, L0_REQ:
            if (flush_i)
               state_d = mem.req_ready_i ? DRAIN : IDLE;
            else if (mem.req_ready_i)
               state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
         L1_WAIT:
            if (flush_i)
               state_d = mem.rsp_valid_i ? IDLE : DRAIN;
            else if (mem.rsp_valid_i) begin
               if (mem.rsp_err_i || p_bad) state_d = FAULT;
               else if (p_leaf)            state_d = (p_misal || p_noacc) ? FAULT : DONE;
               else                        state_d = L0_REQ;
            end
         L0_WAIT:
            if (flush_i)
               state_d = mem.rsp_valid_i ? IDLE : DRAIN;
            else if (mem.rsp_valid_i) begin
               if (mem.rsp_err_i || p_bad || !p_leaf || p_noacc) state_d = FAULT;
               else                                              state_d = DONE;
            end
         DONE, FAULT:
            state_d = IDLE;
         DRAIN:
            if (mem.rsp_valid_i) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vaddr_q       <= '0;
         asid_q        <= '0;
         pte_q         <= '0;
         is_4m_q       <= 1'b0;
         access_q      <= 1'b0;
         fault_vaddr_o <= '0;
      end else begin
         if (state_q == IDLE && miss_valid_i && !flush_i) begin
            vaddr_q       <= miss_vaddr_i;
            asid_q        <= miss_asid_i;
            fault_vaddr_o <= '0;
         end
         if ((state_q == L1_WAIT || state_q == L0_WAIT) && mem.rsp_valid_i && !flush_i) begin
            pte_q    <= mem.rsp_data_i;
            is_4m_q  <= (state_q == L1_WAIT);
            access_q <= mem.rsp_err_i;
         end
         // Reported vaddr becomes visible in the same cycle as the fault pulse
         if (state_d == FAULT && state_q != FAULT)
            fault_vaddr_o <= vaddr_q;
      end
   end

   always_comb begin
      busy_o          = (state_q != IDLE);
      mem.req_valid_o = 1'b0;
      mem.req_addr_o  = '0;
      update_o        = '0;
      fault_o         = 1'b0;
      fault_access_o  = 1'b0;
      unique case (state_q)
         L1_REQ: begin
            mem.req_valid_o = 1'b1;
            mem.req_addr_o  = {satp_ppn_i, 12'b0} + {22'b0, vaddr_q[31:22], 2'b0};
         end
         L0_REQ: begin
            mem.req_valid_o = 1'b1;
            mem.req_addr_o  = {pte_q[31:10], 12'b0} + {22'b0, vaddr_q[21:12], 2'b0};
         end
         DONE:
            if (!flush_i) update_o = {1'b1, is_4m_q, vaddr_q[31:12], asid_q, pte_q};
         FAULT:
            if (!flush_i) begin
               fault_o        = 1'b1;
               fault_access_o = access_q;
            end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sv32_ptw.sv
// Bench for sv32_ptw: directed vector table, randomized walks against a
// page-table reference model, and hand-written flush/backpressure/reset sequences.
module tb_sv32_ptw;
   localparam int AW = 9;
   localparam int UW = 2 + 20 + AW + 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          miss_valid_i = 1'b0;
   logic [31:0]   miss_vaddr_i = '0;
   logic [AW-1:0] miss_asid_i = '0;
   logic [21:0]   satp_ppn_i = '0;
   logic          busy_o, fault_o, fault_access_o;
   logic [UW-1:0] update_o;
   logic [31:0]   fault_vaddr_o;

   sv32_ptw_if mem ();

   sv32_ptw #(.ASID_WIDTH(AW), .PTW_USE_ACCESSED(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .miss_valid_i(miss_valid_i), .miss_vaddr_i(miss_vaddr_i),
      .miss_asid_i(miss_asid_i), .satp_ppn_i(satp_ppn_i), .busy_o(busy_o),
      .mem(mem), .update_o(update_o), .fault_o(fault_o),
      .fault_access_o(fault_access_o), .fault_vaddr_o(fault_vaddr_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] vaddr; logic [AW-1:0] asid; logic [21:0] satp;
      logic [31:0] l1; logic l1e; logic [31:0] l0; logic l0e;
   } walk_t;
   typedef struct {
      int nreq; logic [33:0] a1; logic [33:0] a2;
      logic upd; logic [UW-1:0] u; logic acc; int lat;
   } res_t;
   typedef struct { walk_t w; res_t e; } vec_t;

   int pass = 0;
   int total = 0;

   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   function automatic walk_t mkw(logic [31:0] va, logic [AW-1:0] as, logic [21:0] sp,
                                 logic [31:0] l1, logic l1e, logic [31:0] l0, logic l0e);
      walk_t w;
      w.vaddr = va; w.asid = as; w.satp = sp; w.l1 = l1; w.l1e = l1e; w.l0 = l0; w.l0e = l0e;
      return w;
   endfunction

   function automatic res_t mke(int nreq, logic [33:0] a1, logic [33:0] a2, logic upd,
                                logic [UW-1:0] u, logic acc, int lat);
      res_t r;
      r.nreq = nreq; r.a1 = a1; r.a2 = a2; r.upd = upd; r.u = u; r.acc = acc; r.lat = lat;
      return r;
   endfunction

   function automatic bit pte_ok(logic [31:0] p);
      return p[0] && !(p[2] && !p[1]);
   endfunction

   function automatic bit is_leaf(logic [31:0] p);
      return p[1] || p[3];
   endfunction

   // Reference: table walk from the Sv32 rules, with best-case memory timing
   function automatic res_t model(walk_t w);
      res_t r;
      r = mke(1, 34'(w.satp) * 34'd4096 + 34'(w.vaddr >> 22) * 34'd4, '0, 1'b0, '0, 1'b0, 3);
      if (w.l1e) begin r.acc = 1'b1; return r; end
      if (!pte_ok(w.l1)) return r;
      if (is_leaf(w.l1)) begin
         if (((w.l1 >> 10) % 1024) != 0 || !w.l1[6]) return r;
         r.upd = 1'b1;
         r.u   = {1'b1, 1'b1, w.vaddr[31:12], w.asid, w.l1};
         return r;
      end
      r.nreq = 2;
      r.lat  = 5;
      r.a2   = 34'(w.l1 >> 10) * 34'd4096 + 34'((w.vaddr >> 12) % 1024) * 34'd4;
      if (w.l0e) begin r.acc = 1'b1; return r; end
      if (!pte_ok(w.l0) || !is_leaf(w.l0) || !w.l0[6]) return r;
      r.upd = 1'b1;
      r.u   = {1'b1, 1'b0, w.vaddr[31:12], w.asid, w.l0};
      return r;
   endfunction

   // Memory answers one cycle after each handshake; lat counts cycles from the miss
   task automatic run_walk(input walk_t w, output res_t g, output logic [31:0] fva,
                           output logic busy_after);
      int  cyc;
      bit  pend, done;
      g = mke(0, '0, '0, 1'b0, '0, 1'b0, -1);
      fva = '0;
      satp_ppn_i = w.satp; miss_vaddr_i = w.vaddr; miss_asid_i = w.asid;
      miss_valid_i = 1'b1; mem.req_ready_i = 1'b1;
      @(negedge clk_i);
      miss_valid_i = 1'b0;
      cyc = 1; pend = 0; done = 0;
      while (!done && cyc < 30) begin
         mem.rsp_valid_i = pend;
         mem.rsp_data_i  = (g.nreq == 1) ? w.l1 : w.l0;
         mem.rsp_err_i   = pend && ((g.nreq == 1) ? w.l1e : w.l0e);
         pend = 0;
         #1;
         if (mem.req_valid_o) begin
            if (g.nreq == 0) g.a1 = mem.req_addr_o;
            else             g.a2 = mem.req_addr_o;
            g.nreq++;
            pend = 1;
         end
         if (update_o[UW-1] || fault_o) begin
            g.upd = update_o[UW-1]; g.u = update_o; g.acc = fault_o && fault_access_o;
            g.lat = cyc; fva = fault_vaddr_o; done = 1;
         end
         @(negedge clk_i);
         cyc++;
      end
      mem.rsp_valid_i = 1'b0; mem.rsp_err_i = 1'b0;
      busy_after = busy_o;
   endtask

   task automatic walk_and_check(input string n, input walk_t w, input res_t e);
      res_t g; logic [31:0] fva; logic ba;
      run_walk(w, g, fva, ba);
      check({n, ".nreq"}, 64'(g.nreq), 64'(e.nreq));
      check({n, ".a1"}, 64'(g.a1), 64'(e.a1));
      check({n, ".a2"}, 64'(g.a2), 64'(e.a2));
      check({n, ".upd"}, 64'(g.u), 64'(e.u));
      check({n, ".acc"}, 64'(g.acc), 64'(e.acc));
      check({n, ".lat"}, 64'(g.lat), 64'(e.lat));
      check({n, ".fvaddr"}, 64'(fva), 64'(e.upd ? 32'h0 : w.vaddr));
      check({n, ".busy_after"}, 64'(ba), 64'h0);
   endtask

   function automatic logic [31:0] rand_pte(int k);
      case (k)
         0:       return ($urandom & 32'hFFFFFC00) | 32'h1;
         1:       return ($urandom & 32'hFFF00000) | 32'hCF;
         2:       return ($urandom & 32'hFFFFFC00) | 32'hC7;
         default: return $urandom;
      endcase
   endfunction

   vec_t vt[8];

   initial begin
      logic bad;
      walk_t w;
      mem.req_ready_i = 1'b0; mem.rsp_valid_i = 1'b0; mem.rsp_data_i = '0; mem.rsp_err_i = 1'b0;

      vt[0].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h00024001, 0, 32'h0002ACC7, 0);
      vt[0].e = mke(2, 34'h80120, 34'h90D14, 1, {2'b10, 20'h12345, 9'h001, 32'h0002ACC7}, 0, 5);
      vt[1].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h001000CF, 0, 32'h0, 0);
      vt[1].e = mke(1, 34'h80120, 34'h0, 1, {2'b11, 20'h12345, 9'h001, 32'h001000CF}, 0, 3);
      vt[2].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h001004CF, 0, 32'h0, 0);
      vt[2].e = mke(1, 34'h80120, 34'h0, 0, '0, 0, 3);
      vt[3].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h00024001, 0, 32'h0002ACC7, 1);
      vt[3].e = mke(2, 34'h80120, 34'h90D14, 0, '0, 1, 5);
      vt[4].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h0010008F, 0, 32'h0, 0);
      vt[4].e = mke(1, 34'h80120, 34'h0, 0, '0, 0, 3);
      vt[5].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h00024001, 0, 32'h00000001, 0);
      vt[5].e = mke(2, 34'h80120, 34'h90D14, 0, '0, 0, 5);
      vt[6].w = mkw(32'h12345000, 9'h1, 22'h80, 32'h001000CE, 0, 32'h0, 0);
      vt[6].e = mke(1, 34'h80120, 34'h0, 0, '0, 0, 3);
      vt[7].w = mkw(32'hFFFFF000, 9'h1FF, 22'h3FFFFF, 32'h00000005, 0, 32'h0, 0);
      vt[7].e = mke(1, 34'h3FFFFFFFC, 34'h0, 0, '0, 0, 3);

      repeat (2) @(negedge clk_i);
      #1;
      check("reset.outputs", {busy_o, mem.req_valid_o, fault_o, fault_access_o, update_o},
            64'h0);
      check("reset.addr_fva", {mem.req_addr_o, fault_vaddr_o}, 64'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 8; i++)
         walk_and_check($sformatf("vec%0d", i), vt[i].w, vt[i].e);

      for (int i = 0; i < 30; i++) begin
         w = mkw($urandom, AW'($urandom), 22'($urandom), rand_pte($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, rand_pte($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0);
         walk_and_check($sformatf("rnd%0d", i), w, model(w));
      end

      // Flush while in L1_WAIT; a miss offered during DRAIN must be ignored
      bad = 1'b0;
      satp_ppn_i = 22'h80; miss_vaddr_i = 32'h12345000; miss_valid_i = 1'b1; mem.req_ready_i = 1'b1;
      @(negedge clk_i); miss_valid_i = 1'b0;
      @(negedge clk_i); flush_i = 1'b1;
      #1 check("flush.busy_in_wait", 64'(busy_o), 64'h1);
      @(negedge clk_i); flush_i = 1'b0; miss_valid_i = 1'b1; miss_vaddr_i = 32'hABCDE000;
      for (int c = 0; c < 2; c++) begin
         #1 bad |= update_o[UW-1] | fault_o | mem.req_valid_o;
         @(negedge clk_i);
      end
      miss_valid_i = 1'b0; mem.rsp_valid_i = 1'b1; mem.rsp_data_i = 32'h001000CF;
      #1 check("flush.busy_at_rsp", 64'(busy_o), 64'h1);
      bad |= update_o[UW-1] | fault_o | mem.req_valid_o;
      @(negedge clk_i); mem.rsp_valid_i = 1'b0;
      #1 check("flush.busy_after_rsp", 64'(busy_o), 64'h0);
      bad |= update_o[UW-1] | fault_o;
      @(negedge clk_i);
      #1 check("flush.miss_ignored", 64'({busy_o, mem.req_valid_o}), 64'h0);
      check("flush.no_update_fault", 64'(bad), 64'h0);

      // Flush in L1_REQ with no handshake returns straight to IDLE
      miss_vaddr_i = 32'h12345000; miss_valid_i = 1'b1; mem.req_ready_i = 1'b0;
      @(negedge clk_i); miss_valid_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i); flush_i = 1'b0;
      #1 check("flush_req.idle", 64'({busy_o, mem.req_valid_o, fault_o}), 64'h0);
      @(negedge clk_i);

      // Backpressure then asynchronous reset in L0_WAIT
      miss_valid_i = 1'b1; mem.req_ready_i = 1'b0;
      @(negedge clk_i); miss_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1 check($sformatf("bp.hold%0d", c), {29'h0, mem.req_valid_o, mem.req_addr_o},
                  {29'h0, 1'b1, 34'h80120});
         @(negedge clk_i);
      end
      mem.req_ready_i = 1'b1;
      @(negedge clk_i);
      mem.rsp_valid_i = 1'b1; mem.rsp_data_i = 32'h00024001;
      @(negedge clk_i); mem.rsp_valid_i = 1'b0;
      #1 check("bp.l0_addr", 64'(mem.req_addr_o), 64'h90D14);
      @(negedge clk_i);
      #1 check("rst.busy_before", 64'(busy_o), 64'h1);
      #1 rst_ni = 1'b0;
      #1 check("rst.async_outputs",
               {busy_o, mem.req_valid_o, fault_o, fault_access_o, update_o}, 64'h0);
      check("rst.async_addr_fva", {mem.req_addr_o, fault_vaddr_o}, 64'h0);
      @(negedge clk_i); rst_ni = 1'b1;
      @(negedge clk_i);
      walk_and_check("post_reset", vt[0].w, vt[0].e);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
